trace_r3_monitor: RTL and testbench

- Synthesizable per-core execution-trace monitor for a compute tile with one or more cores.
- Consumes the core's writeback trace (enable, pc, insn, writeback register and data) and keeps a shadow copy of GPR r3.
- Decodes OR1K l.nop simulation hooks (exit, report, putc, event) into pulse outputs.
- Combines per-core termination flags into a tile-wide all-terminated flag; one instance per core.

---
 rtl/trace_r3_monitor.sv | 77 +++++++
 tb/tb_trace_r3_monitor.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/trace_r3_monitor.sv
// trace_r3_monitor: per-core writeback trace monitor with a shadow r3 and l.nop hook decode.
// Exit is sticky; it freezes the instruction count and suppresses later hooks.
module trace_r3_monitor #(
   parameter int ID             = 0,
   parameter int TERM_CROSS_NUM = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic [31:0]               wb_pc,
   input  logic [31:0]               wb_insn,
   input  logic                      wb_en,
   input  logic [4:0]                wb_reg,
   input  logic [31:0]               wb_data,
   input  logic [TERM_CROSS_NUM-1:0] termination_all,
   output logic [31:0]               r3,
   output logic                      termination,
   output logic [31:0]               exit_code,
   output logic                      putc_valid,
   output logic [7:0]                putc_char,
   output logic                      report_valid,
   output logic [31:0]               report_value,
   output logic                      event_valid,
   output logic [7:0]                event_id,
   output logic [31:0]               event_value,
   output logic [31:0]               event_pc,
   output logic [7:0]                event_core,
   output logic [31:0]               insn_count,
   output logic                      all_terminated
);
   localparam logic [7:0] core_id = 8'(ID);
   logic [31:0] r3_q;
   logic [15:0] k;
   logic r3_wr, hook, live;
   assign r3_wr = enable & wb_en & (wb_reg == 5'd3);
   assign r3    = r3_wr ? wb_data : r3_q;
   assign k     = wb_insn[15:0];
   assign hook  = enable & (wb_insn[31:24] == 8'h15);
   assign live  = hook & ~termination;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r3_q           <= '0;
         termination    <= 1'b0;
         exit_code      <= '0;
         putc_valid     <= 1'b0;
         putc_char      <= '0;
         report_valid   <= 1'b0;
         report_value   <= '0;
         event_valid    <= 1'b0;
         event_id       <= '0;
         event_value    <= '0;
         event_pc       <= '0;
         event_core     <= '0;
         insn_count     <= '0;
         all_terminated <= 1'b0;
      end else begin
         putc_valid     <= live & (k == 16'h0004);
         report_valid   <= live & (k == 16'h0002);
         event_valid    <= live & (k[15:8] == 8'h20);
         all_terminated <= &termination_all;
         if (r3_wr) r3_q <= wb_data;
         if (enable & ~termination) insn_count <= insn_count + 32'd1;
         if (live & (k == 16'h0001)) begin
            termination <= 1'b1;
            exit_code   <= r3;
         end
         if (live & (k == 16'h0004)) putc_char <= r3[7:0];
         if (live & (k == 16'h0002)) report_value <= r3;
         if (live & (k[15:8] == 8'h20)) begin
            event_id    <= k[7:0];
            event_value <= r3;
            event_pc    <= wb_pc;
            event_core  <= core_id;
         end
      end
   end
endmodule

// File: tb/tb_trace_r3_monitor.sv
// tb_trace_r3_monitor: directed and random trace entries checked against a rule-level model.
module tb_trace_r3_monitor;
   logic clk = 0, rst_n = 0, enable = 0, wb_en = 0;
   logic [31:0] wb_pc = 0, wb_insn = 0, wb_data = 0;
   logic [4:0] wb_reg = 0;
   logic [1:0] tall = 0;
   logic [31:0] r3, exit_code, report_value, event_value, event_pc, insn_count;
   logic termination, putc_valid, report_valid, event_valid, all_terminated;
   logic [7:0] putc_char, event_id, event_core;
   int total = 0, bad = 0;
   logic [31:0] m_r3, m_exit, m_cnt, e_rep, e_evv, e_evpc;
   logic m_term, m_all, e_pv, e_rv, e_ev;
   logic [7:0] e_pc, e_eid, e_core;

   trace_r3_monitor #(.ID(1), .TERM_CROSS_NUM(2)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .wb_pc(wb_pc), .wb_insn(wb_insn),
      .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .termination_all(tall),
      .r3(r3), .termination(termination), .exit_code(exit_code), .putc_valid(putc_valid),
      .putc_char(putc_char), .report_valid(report_valid), .report_value(report_value),
      .event_valid(event_valid), .event_id(event_id), .event_value(event_value),
      .event_pc(event_pc), .event_core(event_core), .insn_count(insn_count),
      .all_terminated(all_terminated));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      {m_r3, m_exit, m_cnt, e_rep, e_evv, e_evpc} = '0;
      {m_term, m_all, e_pv, e_rv, e_ev, e_pc, e_eid, e_core} = '0;
   endtask

   task automatic check_all();
      chk("termination", termination, m_term);
      chk("exit_code", exit_code, m_exit);
      chk("insn_count", insn_count, m_cnt);
      chk("putc_valid", putc_valid, e_pv);
      chk("putc_char", putc_char, e_pc);
      chk("report_valid", report_valid, e_rv);
      chk("report_value", report_value, e_rep);
      chk("event_valid", event_valid, e_ev);
      chk("event_id", event_id, e_eid);
      chk("event_value", event_value, e_evv);
      chk("event_pc", event_pc, e_evpc);
      chk("event_core", event_core, e_core);
      chk("all_terminated", all_terminated, m_all);
   endtask

   task automatic step(input logic en, input logic [31:0] pc, input logic [31:0] insn,
                       input logic wen, input logic [4:0] rg, input logic [31:0] data);
      logic [31:0] byp;
      logic [15:0] k;
      logic hook;
      @(negedge clk);
      enable = en; wb_pc = pc; wb_insn = insn; wb_en = wen; wb_reg = rg; wb_data = data;
      #1;
      byp = (en && wen && rg == 5'd3) ? data : m_r3;
      chk("r3_comb", r3, byp);
      k = insn[15:0];
      hook = en && insn[31:24] == 8'h15 && !m_term;
      e_pv = hook && k == 16'h0004;
      e_rv = hook && k == 16'h0002;
      e_ev = hook && k[15:8] == 8'h20;
      if (e_pv) e_pc = byp[7:0];
      if (e_rv) e_rep = byp;
      if (e_ev) begin e_eid = k[7:0]; e_evv = byp; e_evpc = pc; e_core = 8'd1; end
      if (en && !m_term) m_cnt++;
      if (hook && k == 16'h0001) begin m_term = 1; m_exit = byp; end
      if (en && wen && rg == 5'd3) m_r3 = data;
      m_all = &tall;
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic set_r3(input logic [31:0] v);
      step(1, 32'h0, 32'h9c000000, 1, 5'd3, v);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0; enable = 0; tall = 0;
      #1;
      model_clear();
      check_all();
      chk("r3_reset", r3, 32'h0);
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      do_reset();
      // shadow r3 write, hold, and ignored write to r4
      step(1, 32'h0, 32'h9c000000, 1, 5'd3, 32'h41);
      step(0, 32'h0, 32'h0, 0, 5'd0, 32'h0);
      chk("r3_hold", r3, 32'h41);
      step(1, 32'h4, 32'h9c000000, 1, 5'd4, 32'h77);
      chk("r3_other_reg", r3, 32'h41);
      // putc single and back-to-back
      set_r3(32'h48);
      step(1, 32'h8, 32'h15000004, 0, 5'd0, 32'h0);
      chk("putc_char_48", putc_char, 32'h48);
      step(1, 32'hc, 32'h15000004, 1, 5'd3, 32'h69);
      chk("putc_b2b_valid", putc_valid, 32'h1);
      chk("putc_b2b_char", putc_char, 32'h69);
      step(0, 32'h0, 32'h0, 0, 5'd0, 32'h0);
      chk("putc_single_cycle", putc_valid, 32'h0);
      // report and event
      set_r3(32'hdeadbeef);
      step(1, 32'h10, 32'h15000002, 0, 5'd0, 32'h0);
      chk("report_value", report_value, 32'hdeadbeef);
      step(1, 32'h100, 32'h15002005, 0, 5'd0, 32'h0);
      chk("event_id_05", event_id, 32'h05);
      chk("event_pc_100", event_pc, 32'h100);
      chk("event_core_1", event_core, 32'h1);
      // random phase, exit excluded so hooks stay live
      for (int i = 0; i < 300; i++) begin
         logic [31:0] ins;
         logic [15:0] kk;
         kk = 16'($urandom);
         if (kk == 16'h0001) kk = 16'h0003;
         case ($urandom_range(0, 4))
            0: ins = 32'h15000002;
            1: ins = 32'h15000004;
            2: ins = {16'h1500, 8'h20, 8'($urandom)};
            3: ins = {16'h1500, kk};
            default: ins = {8'h9c, 24'($urandom)};
         endcase
         tall = 2'($urandom);
         step(1'($urandom), $urandom, ins, 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      end
      // exit after 10 instructions
      do_reset();
      for (int i = 0; i < 10; i++) step(1, 32'(i * 4), 32'h9c000000, 0, 5'd0, 32'h0);
      step(1, 32'h28, 32'h15000001, 0, 5'd0, 32'h0);
      chk("exit_term", termination, 32'h1);
      chk("exit_code_0", exit_code, 32'h0);
      chk("exit_count_11", insn_count, 32'd11);
      step(1, 32'h2c, 32'h15000004, 0, 5'd0, 32'h0);
      chk("putc_suppressed", putc_valid, 32'h0);
      chk("count_frozen", insn_count, 32'd11);
      set_r3(32'h5);
      step(1, 32'h30, 32'h15000001, 0, 5'd0, 32'h0);
      chk("second_exit_ignored", exit_code, 32'h0);
      // tile-wide termination
      tall = 2'b01;
      step(0, 32'h0, 32'h0, 0, 5'd0, 32'h0);
      chk("all_term_01", all_terminated, 32'h0);
      tall = 2'b11;
      step(0, 32'h0, 32'h0, 0, 5'd0, 32'h0);
      chk("all_term_11", all_terminated, 32'h1);
      // asynchronous reset between edges
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk("async_term", termination, 32'h0);
      chk("async_count", insn_count, 32'h0);
      chk("async_r3", r3, 32'h0);
      chk("async_all", all_terminated, 32'h0);
      #10 rst_n = 1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
